// File: rtl/vec_lane_array.sv
// rtl/vec_lane_array.sv - multi-lane vector execution unit with vl/tail handling and slides
// Optional element masking is enabled by defining VEC_MASK_EN.
module vec_lane_array #(
  parameter int ELEN   = 64,
  parameter int MAX_VL = 16,
  parameter int LANES  = 4,
  parameter int VLW    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             funct6,
  input  logic                   op_vx,
  input  logic [VLW-1:0]         vl,
  input  logic [ELEN-1:0]        scalar_in,
  input  logic [MAX_VL*ELEN-1:0] vs1,
  input  logic [MAX_VL*ELEN-1:0] vs2,
  input  logic [MAX_VL*ELEN-1:0] vd_old,
  input  logic [MAX_VL-1:0]      v0_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [MAX_VL*ELEN-1:0] vd,
  output logic                   illegal,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_VADD   = 6'b000000;
  localparam logic [5:0] OP_VSUB   = 6'b000010;
  localparam logic [5:0] OP_VAND   = 6'b001001;
  localparam logic [5:0] OP_VOR    = 6'b001010;
  localparam logic [5:0] OP_VXOR   = 6'b001011;
  localparam logic [5:0] OP_VMV    = 6'b010111;
  localparam logic [5:0] OP_VSLUP  = 6'b001110;
  localparam logic [5:0] OP_VSLDN  = 6'b001111;

  localparam int GW = VLW + 1;

  logic [1:0]             r_state;
  logic [5:0]             r_funct6;
  logic                   r_op_vx;
  logic [VLW-1:0]         r_vl;
  logic [VLW-1:0]         r_off;
  logic [ELEN-1:0]        r_scalar;
  logic [MAX_VL*ELEN-1:0] r_vs1;
  logic [MAX_VL*ELEN-1:0] r_vs2;
  logic [MAX_VL*ELEN-1:0] r_vd_old;
  logic [MAX_VL*ELEN-1:0] r_vd;
  logic [GW-1:0]          r_g;
  logic [GW-1:0]          r_ngrp;
  logic                   r_illegal;

  logic [VLW-1:0]         w_vl_clamp;
  logic [VLW-1:0]         w_off;
  logic [GW-1:0]          w_ngrp;
  logic                   w_legal;
  logic [ELEN-1:0]        w_res [LANES];
  logic [LANES-1:0]       w_act;

`ifdef VEC_MASK_EN
  logic [MAX_VL-1:0]      r_mask;
`else
  logic                   w_unused_mask;
  assign w_unused_mask = ^v0_mask;
`endif

  assign w_vl_clamp = (vl > VLW'(MAX_VL)) ? VLW'(MAX_VL) : vl;
  assign w_off      = (scalar_in > ELEN'(MAX_VL)) ? VLW'(MAX_VL) : scalar_in[VLW-1:0];
  assign w_ngrp     = GW'((int'(w_vl_clamp) + LANES - 1) / LANES);
  assign w_legal    = funct6 inside {OP_VADD, OP_VSUB, OP_VAND, OP_VOR, OP_VXOR,
                                     OP_VMV, OP_VSLUP, OP_VSLDN};

  // One group of LANES consecutive elements per cycle; tail lanes stay inactive.
  always_comb begin
    int idx;
    int off;
    logic [ELEN-1:0] a;
    logic [ELEN-1:0] b;
    logic [ELEN-1:0] old;
    idx = 0;
    off = int'(r_off);
    a   = '0;
    b   = '0;
    old = '0;
    for (int l = 0; l < LANES; l++) begin
      idx      = int'(r_g) * LANES + l;
      w_res[l] = '0;
      w_act[l] = 1'b0;
      if (idx < MAX_VL) begin
        a        = r_vs2[idx*ELEN +: ELEN];
        b        = r_op_vx ? r_scalar : r_vs1[idx*ELEN +: ELEN];
        old      = r_vd_old[idx*ELEN +: ELEN];
        w_act[l] = idx < int'(r_vl);
        case (r_funct6)
          OP_VADD: w_res[l] = a + b;
          OP_VSUB: w_res[l] = a - b;
          OP_VAND: w_res[l] = a & b;
          OP_VOR:  w_res[l] = a | b;
          OP_VXOR: w_res[l] = a ^ b;
          OP_VMV:  w_res[l] = b;
          OP_VSLUP: begin
            if (idx < off) w_res[l] = old;
            else           w_res[l] = r_vs2[(idx-off)*ELEN +: ELEN];
          end
          OP_VSLDN: begin
            if (idx + off < MAX_VL) w_res[l] = r_vs2[(idx+off)*ELEN +: ELEN];
            else                    w_res[l] = '0;
          end
          default: w_res[l] = '0;
        endcase
`ifdef VEC_MASK_EN
        if (!r_mask[idx]) w_res[l] = old;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_funct6  <= '0;
      r_op_vx   <= 1'b0;
      r_vl      <= '0;
      r_off     <= '0;
      r_scalar  <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vd_old  <= '0;
      r_vd      <= '0;
      r_g       <= '0;
      r_ngrp    <= '0;
      r_illegal <= 1'b0;
`ifdef VEC_MASK_EN
      r_mask    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_funct6  <= funct6;
            r_op_vx   <= op_vx;
            r_vl      <= w_vl_clamp;
            r_off     <= w_off;
            r_scalar  <= scalar_in;
            r_vs1     <= vs1;
            r_vs2     <= vs2;
            r_vd_old  <= vd_old;
            r_vd      <= vd_old;
            r_g       <= '0;
            r_ngrp    <= w_ngrp;
            r_illegal <= !w_legal;
`ifdef VEC_MASK_EN
            r_mask    <= v0_mask;
`endif
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_g == r_ngrp) begin
            r_state <= S_DONE;
          end else begin
            for (int l = 0; l < LANES; l++) begin
              if (w_act[l]) r_vd[(int'(r_g)*LANES + l)*ELEN +: ELEN] <= w_res[l];
            end
            r_g <= r_g + GW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign illegal   = (r_state == S_DONE) && r_illegal;
  assign vd        = r_vd;

endmodule
